store_buffer: RTL

Write-through store buffer between the MEM-stage D-cache and the shared single-port main memory (memory4c). Stores from the pipeline are queued here instead of stalling on memory. The buffer drains them to memory in cycles the cache-fill FSM does not own the port. It also holds off any fill whose block address matches a pending store, so a fill can never read stale data.

---
 rtl/store_buffer_if.sv | 36 +++
 rtl/store_buffer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/store_buffer_if.sv
// store_buffer_if
//   Bundles the three buses of the write-through store buffer.
//   Store port : st_valid/st_addr/st_data in, st_ready out.
//   Fill port  : fill_req/fill_addr/fill_busy in, fill_hold out.
//   Memory port: mem_en/mem_wr/mem_addr/mem_data out (drain writes).
//   The slave modport is the buffer's view. The master modport is the
//   view of the pipeline, fill FSM and memory side.
interface store_buffer_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          st_ready;

    logic          fill_req;
    logic [AW-1:0] fill_addr;
    logic          fill_busy;
    logic          fill_hold;

    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;

    modport slave (
        input  st_valid, st_addr, st_data, fill_req, fill_addr, fill_busy,
        output st_ready, fill_hold, mem_en, mem_wr, mem_addr, mem_data
    );

    modport master (
        output st_valid, st_addr, st_data, fill_req, fill_addr, fill_busy,
        input  st_ready, fill_hold, mem_en, mem_wr, mem_addr, mem_data
    );
endinterface

// File: rtl/store_buffer.sv
// store_buffer
//   Write-through store buffer between the MEM-stage D-cache and the
//   single-port main memory. Stores are queued in a circular FIFO and
//   drained in program order, one per cycle, whenever the fill FSM
//   does not own the memory port. A fill whose block matches a pending
//   (or incoming) store is held until that store has drained.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    store_buffer_if.slave (store, fill and memory buses)
//   empty  no pending stores
//   count  number of pending stores
module store_buffer #(
    parameter int DEPTH   = 4,
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int BLK_LSB = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    store_buffer_if.slave            bus,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    // Mask selecting the block-address bits of an address.
    localparam logic [AW-1:0] BLK_MASK = {{(AW-BLK_LSB){1'b1}}, {BLK_LSB{1'b0}}};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] addr_q [DEPTH];
    logic [AW-1:0] addr_d [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];
    logic          valid_q [DEPTH];
    logic          valid_d [DEPTH];

    logic          full;
    logic          push;
    logic          grant;
    logic          block_match;
    logic [PW-1:0] count_w;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;

    assign wr_idx  = wr_ptr_q[IW-1:0];
    assign rd_idx  = rd_ptr_q[IW-1:0];
    assign count_w = wr_ptr_q - rd_ptr_q;

    // Full when the index bits agree but the wrap bits differ.
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_idx == rd_idx);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign count = count_w;

    // st_ready comes from registered state only; a pop in the same
    // cycle does not open a slot early.
    assign bus.st_ready = ~full;
    assign push         = bus.st_valid & ~full;

    // A fill conflicts with any valid entry in its block, and also with
    // a store being pushed this very cycle.
    always_comb begin
        block_match = push && (((bus.st_addr ^ bus.fill_addr) & BLK_MASK) == '0);
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (((addr_q[i] ^ bus.fill_addr) & BLK_MASK) == '0)) begin
                block_match = 1'b1;
            end
        end
    end

    assign bus.fill_hold = bus.fill_req & block_match;

    // A fill normally wins the port; a held fill yields it so the
    // conflicting store can drain and unblock it.
    assign grant = ~empty & ~bus.fill_busy & (~bus.fill_req | bus.fill_hold)
                 & (state_q == DRAIN);

    assign bus.mem_en   = grant;
    assign bus.mem_wr   = grant;
    assign bus.mem_addr = empty ? '0 : addr_q[rd_idx];
    assign bus.mem_data = empty ? '0 : data_q[rd_idx];

    // FIFO next state: write at the tail on push, retire the head on grant.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            addr_d[i]  = addr_q[i];
            data_d[i]  = data_q[i];
            valid_d[i] = valid_q[i];
        end
        if (grant) begin
            valid_d[rd_idx] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PW'(1);
        end
        if (push) begin
            addr_d[wr_idx]  = bus.st_addr;
            data_d[wr_idx]  = bus.st_data;
            valid_d[wr_idx] = 1'b1;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
    end

    // Drain FSM next state. Leaving DRAIN on the last pop only applies
    // when no new store arrives in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (empty) begin
                    state_d = IDLE;
                end else if (grant && !push && (count_w == PW'(1))) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i]  <= '0;
                data_q[i]  <= '0;
                valid_q[i] <= 1'b0;
            end
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i]  <= addr_d[i];
                data_q[i]  <= data_d[i];
                valid_q[i] <= valid_d[i];
            end
        end
    end
endmodule
